// File: rtl/cpu_ctl_pkg.sv
// Shared types for the CPU run controller: FSM states, host opcodes, response codes.
package cpu_ctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_ADDR = 3'd2,
    S_READ_CAP  = 3'd3,
    S_START     = 3'd4,
    S_RUN       = 3'd5,
    S_RESP      = 3'd6
  } ctl_state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RUN   = 2'b10
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BAD_OP  = 2'b10
  } rsp_status_t;

endpackage

// File: rtl/cpu_run_controller.sv
// Host-side sequencer for the 9-bit-ISA core: preloads data memory, launches a
// run, times it until cpu_done (or timeout), reads back results, and returns one
// response per host command over a valid/ready handshake.
module cpu_run_controller
  import cpu_ctl_pkg::*;
#(
  parameter int unsigned      ADDR_W  = 8,
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(16'hFFF0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              busy
);

  ctl_state_t           state_q;
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  rsp_status_t          rsp_status_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic                 mem_wen_q;
  logic                 cpu_start_q;
  logic [CNT_W-1:0]     cycle_count_q;
  logic                 busy_q;
  logic                 run_first_q;

  // Count value including the current RUN cycle.
  logic [CNT_W-1:0]     cnt_inc_d;
  assign cnt_inc_d = cycle_count_q + CNT_W'(1);

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= ST_OK;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wen_q     <= 1'b0;
      cpu_start_q   <= 1'b0;
      cycle_count_q <= '0;
      busy_q        <= 1'b0;
      run_first_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            case (cmd_op)
              OP_WRITE: begin
                state_q     <= S_WRITE;
                mem_addr_q  <= cmd_addr;
                mem_wdata_q <= cmd_wdata;
                mem_wen_q   <= 1'b1;
              end
              OP_READ: begin
                state_q    <= S_READ_ADDR;
                mem_addr_q <= cmd_addr;
              end
              OP_RUN: begin
                state_q       <= S_START;
                mem_addr_q    <= cmd_addr;
                cpu_start_q   <= 1'b1;
                cycle_count_q <= '0;
              end
              default: begin
                state_q      <= S_RESP;
                rsp_valid_q  <= 1'b1;
                rsp_data_q   <= '0;
                rsp_status_q <= ST_BAD_OP;
              end
            endcase
          end
        end

        // Single write strobe, then acknowledge.
        S_WRITE: begin
          mem_wen_q    <= 1'b0;
          state_q      <= S_RESP;
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= '0;
          rsp_status_q <= ST_OK;
        end

        // Address is already on the port; give a registered memory a cycle.
        S_READ_ADDR: begin
          state_q <= S_READ_CAP;
        end

        S_READ_CAP: begin
          state_q      <= S_RESP;
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= mem_rdata;
          rsp_status_q <= ST_OK;
        end

        S_START: begin
          cpu_start_q <= 1'b0;
          run_first_q <= 1'b1;
          state_q     <= S_RUN;
        end

        // Done is ignored on the first RUN cycle (stale from a prior run); done beats timeout.
        S_RUN: begin
          run_first_q <= 1'b0;
          if (!run_first_q && cpu_done) begin
            cycle_count_q <= cnt_inc_d;
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= DATA_W'(cnt_inc_d);
            rsp_status_q  <= ST_OK;
          end else if (cnt_inc_d == TIMEOUT) begin
            cycle_count_q <= TIMEOUT;
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= {DATA_W{1'b1}};
            rsp_status_q  <= ST_TIMEOUT;
          end else begin
            cycle_count_q <= cnt_inc_d;
          end
        end

        // Hold the response until the host takes it; the next command waits a cycle.
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_wen_q   <= 1'b0;
          cpu_start_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wen     = mem_wen_q;
  assign cpu_start   = cpu_start_q;
  assign cycle_count = cycle_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: a main instance with the default timeout
// and a second instance with TIMEOUT=20 for the abort and tie cases.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_valid_t, rsp_ready, cpu_done;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr, cmd_wdata;

  logic        cmd_ready, rsp_valid, mem_wen, cpu_start, busy;
  logic [7:0]  rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  rsp_status;
  logic [15:0] cycle_count;

  logic        cmd_ready_t, rsp_valid_t, mem_wen_t, cpu_start_t, busy_t;
  logic [7:0]  rsp_data_t, mem_addr_t, mem_wdata_t, mem_rdata_t;
  logic [1:0]  rsp_status_t;
  logic [15:0] cycle_count_t;

  int nvec = 0;
  int nerr = 0;
  int wen_total = 0;
  int start_total = 0;

  localparam logic [46:0] RST_VEC = {1'b1, 46'd0};

  cpu_run_controller dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .cycle_count(cycle_count), .busy(busy)
  );

  cpu_run_controller #(.TIMEOUT(16'd20)) dut_to (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready), .rsp_data(rsp_data_t), .rsp_status(rsp_status_t),
    .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_wen(mem_wen_t), .mem_rdata(mem_rdata_t),
    .cpu_start(cpu_start_t), .cpu_done(cpu_done), .cycle_count(cycle_count_t), .busy(busy_t)
  );

  // Data memory model with combinational read.
  logic [7:0] mem_q [0:255];
  always @(posedge clk) if (mem_wen === 1'b1) mem_q[mem_addr] <= mem_wdata;
  assign mem_rdata   = mem_q[mem_addr];
  assign mem_rdata_t = 8'h00;

  // Free-running event counters; tests use deltas.
  always @(posedge clk) begin
    if (mem_wen === 1'b1 || mem_wen_t === 1'b1) wen_total <= wen_total + 1;
    if (cpu_start === 1'b1 || cpu_start_t === 1'b1) start_total <= start_total + 1;
  end

  function automatic logic [46:0] pack_main();
    return {cmd_ready, rsp_valid, rsp_data, rsp_status, mem_addr, mem_wdata,
            mem_wen, cpu_start, cycle_count, busy};
  endfunction

  function automatic logic [46:0] pack_to();
    return {cmd_ready_t, rsp_valid_t, rsp_data_t, rsp_status_t, mem_addr_t, mem_wdata_t,
            mem_wen_t, cpu_start_t, cycle_count_t, busy_t};
  endfunction

  // Present one command for one cycle; called at a negedge with the target idle.
  task automatic send_cmd(input bit sel, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    cmd_op = op; cmd_addr = a; cmd_wdata = d;
    if (sel) cmd_valid_t = 1'b1; else cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_valid_t = 1'b0;
  endtask

  // Wait (bounded) for a response, capture it, and complete the handshake.
  task automatic wait_rsp(input bit sel, output bit seen, output logic [7:0] d, output logic [1:0] st);
    seen = 1'b0; d = 8'h00; st = 2'b00;
    for (int i = 0; i < 200 && !seen; i++) begin
      if ((sel ? rsp_valid_t : rsp_valid) === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (seen) begin
      d  = sel ? rsp_data_t : rsp_data;
      st = sel ? rsp_status_t : rsp_status;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    nvec++;
    if (pack_main() !== RST_VEC) begin
      nerr++; $display("FAIL reset_main got=%h exp=%h", pack_main(), RST_VEC);
    end
    nvec++;
    if (pack_to() !== RST_VEC) begin
      nerr++; $display("FAIL reset_to got=%h exp=%h", pack_to(), RST_VEC);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [7:0] wa [3] = '{8'h10, 8'hFF, 8'h00};
    logic [7:0] wd [3] = '{8'hA5, 8'h3C, 8'hC3};
    bit seen; logic [7:0] d; logic [1:0] st; int w0;
    for (int k = 0; k < 3; k++) begin
      w0 = wen_total;
      send_cmd(1'b0, 2'b00, wa[k], wd[k]);
      nvec++;
      if (mem_wen !== 1'b1 || mem_addr !== wa[k] || mem_wdata !== wd[k]) begin
        nerr++; $display("FAIL write_port[%0d] got wen=%b addr=%h data=%h exp wen=1 addr=%h data=%h",
                         k, mem_wen, mem_addr, mem_wdata, wa[k], wd[k]);
      end
      wait_rsp(1'b0, seen, d, st);
      nvec++;
      if (!seen || st !== 2'b00 || d !== 8'h00) begin
        nerr++; $display("FAIL write_rsp[%0d] got seen=%b st=%b data=%h exp seen=1 st=00 data=00", k, seen, st, d);
      end
      nvec++;
      if (wen_total - w0 !== 1) begin
        nerr++; $display("FAIL write_wen_cycles[%0d] got=%0d exp=1", k, wen_total - w0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      w0 = wen_total;
      send_cmd(1'b0, 2'b01, wa[k], 8'h00);
      wait_rsp(1'b0, seen, d, st);
      nvec++;
      if (!seen || st !== 2'b00 || d !== wd[k]) begin
        nerr++; $display("FAIL read_rsp[%0d] got seen=%b st=%b data=%h exp seen=1 st=00 data=%h", k, seen, st, d, wd[k]);
      end
      nvec++;
      if (wen_total != w0) begin
        nerr++; $display("FAIL read_no_wen[%0d] got=%0d exp=0", k, wen_total - w0);
      end
    end
  endtask

  task automatic test_run_done;
    bit seen; logic [7:0] d; logic [1:0] st; int s0; int busy_bad;
    s0 = start_total;
    cpu_done = 1'b0;
    send_cmd(1'b0, 2'b10, 8'h00, 8'h00);
    nvec++;
    if (cpu_start !== 1'b1) begin
      nerr++; $display("FAIL run_start_pulse got=%b exp=1", cpu_start);
    end
    busy_bad = 0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || mem_wen !== 1'b0) busy_bad++;
    end
    cpu_done = 1'b1;
    wait_rsp(1'b0, seen, d, st);
    nvec++;
    if (busy_bad != 0) begin
      nerr++; $display("FAIL run_busy got_bad_cycles=%0d exp=0", busy_bad);
    end
    nvec++;
    if (!seen || st !== 2'b00 || d !== 8'd37) begin
      nerr++; $display("FAIL run_rsp got seen=%b st=%b data=%0d exp seen=1 st=00 data=37", seen, st, d);
    end
    nvec++;
    if (cycle_count !== 16'd37) begin
      nerr++; $display("FAIL run_cycle_count got=%0d exp=37", cycle_count);
    end
    nvec++;
    if (start_total - s0 !== 1) begin
      nerr++; $display("FAIL run_start_count got=%0d exp=1", start_total - s0);
    end
  endtask

  task automatic test_stale_done;
    bit seen; logic [7:0] d; logic [1:0] st;
    cpu_done = 1'b1;
    send_cmd(1'b0, 2'b10, 8'h00, 8'h00);
    wait_rsp(1'b0, seen, d, st);
    cpu_done = 1'b0;
    nvec++;
    if (!seen || st !== 2'b00 || d !== 8'd2) begin
      nerr++; $display("FAIL stale_done_rsp got seen=%b st=%b data=%0d exp seen=1 st=00 data=2", seen, st, d);
    end
    nvec++;
    if (cycle_count !== 16'd2) begin
      nerr++; $display("FAIL stale_done_count got=%0d exp=2", cycle_count);
    end
  endtask

  task automatic test_timeout;
    bit seen; logic [7:0] d; logic [1:0] st;
    cpu_done = 1'b0;
    send_cmd(1'b1, 2'b10, 8'h00, 8'h00);
    wait_rsp(1'b1, seen, d, st);
    nvec++;
    if (!seen || st !== 2'b01 || d !== 8'hFF) begin
      nerr++; $display("FAIL timeout_rsp got seen=%b st=%b data=%h exp seen=1 st=01 data=ff", seen, st, d);
    end
    nvec++;
    if (cycle_count_t !== 16'd20) begin
      nerr++; $display("FAIL timeout_count got=%0d exp=20", cycle_count_t);
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (cycle_count_t !== 16'd20 || busy_t !== 1'b0) begin
      nerr++; $display("FAIL timeout_hold got count=%0d busy=%b exp count=20 busy=0", cycle_count_t, busy_t);
    end
  endtask

  task automatic test_done_timeout_tie;
    bit seen; logic [7:0] d; logic [1:0] st;
    cpu_done = 1'b0;
    send_cmd(1'b1, 2'b10, 8'h00, 8'h00);
    repeat (20) @(negedge clk);
    cpu_done = 1'b1;
    wait_rsp(1'b1, seen, d, st);
    cpu_done = 1'b0;
    nvec++;
    if (!seen || st !== 2'b00 || d !== 8'd20) begin
      nerr++; $display("FAIL tie_rsp got seen=%b st=%b data=%0d exp seen=1 st=00 data=20", seen, st, d);
    end
    nvec++;
    if (cycle_count_t !== 16'd20) begin
      nerr++; $display("FAIL tie_count got=%0d exp=20", cycle_count_t);
    end
  endtask

  task automatic test_bad_op;
    int w0; int s0;
    w0 = wen_total; s0 = start_total;
    send_cmd(1'b0, 2'b11, 8'h44, 8'h55);
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_status !== 2'b10 || cmd_ready !== 1'b0) begin
        nerr++; $display("FAIL bad_op_hold[%0d] got valid=%b data=%h st=%b rdy=%b exp valid=1 data=00 st=10 rdy=0",
                         i, rsp_valid, rsp_data, rsp_status, cmd_ready);
      end
      @(negedge clk);
    end
    // Offer a WRITE during the handshake cycle; it must not be taken.
    rsp_ready = 1'b1;
    cmd_op = 2'b00; cmd_addr = 8'h44; cmd_wdata = 8'h77; cmd_valid = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    nvec++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || mem_wen !== 1'b0) begin
      nerr++; $display("FAIL bad_op_release got rdy=%b valid=%b busy=%b wen=%b exp rdy=1 valid=0 busy=0 wen=0",
                       cmd_ready, rsp_valid, busy, mem_wen);
    end
    @(negedge clk);
    nvec++;
    if (wen_total != w0 || start_total != s0) begin
      nerr++; $display("FAIL bad_op_side_effects got wen=%0d start=%0d exp 0 0", wen_total - w0, start_total - s0);
    end
  endtask

  task automatic test_reset_in_run;
    bit seen; logic [7:0] d; logic [1:0] st; int spurious;
    cpu_done = 1'b0;
    send_cmd(1'b0, 2'b10, 8'h9A, 8'h00);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    nvec++;
    if (pack_main() !== RST_VEC) begin
      nerr++; $display("FAIL reset_in_run got=%h exp=%h", pack_main(), RST_VEC);
    end
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cpu_start !== 1'b0) spurious++;
    end
    nvec++;
    if (spurious != 0) begin
      nerr++; $display("FAIL reset_no_rsp got_bad_cycles=%0d exp=0", spurious);
    end
    send_cmd(1'b0, 2'b00, 8'h20, 8'h5A);
    wait_rsp(1'b0, seen, d, st);
    send_cmd(1'b0, 2'b01, 8'h20, 8'h00);
    wait_rsp(1'b0, seen, d, st);
    nvec++;
    if (!seen || st !== 2'b00 || d !== 8'h5A) begin
      nerr++; $display("FAIL post_reset_read got seen=%b st=%b data=%h exp seen=1 st=00 data=5a", seen, st, d);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_valid_t = 1'b0; rsp_ready = 1'b0; cpu_done = 1'b0;
    cmd_op = 2'b00; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    test_reset();
    test_write_read();
    test_run_done();
    test_stale_done();
    test_timeout();
    test_done_timeout_tie();
    test_bad_op();
    test_reset_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Host-side sequencer that sits directly upstream of the 9-bit-ISA CPU core.
- Preloads the core's data memory byte by byte, launches a program run via cpu_start, and measures cycles until cpu_done.
- Reads back results and returns one response per host command over a valid/ready handshake.
- Owns the data-memory port whenever the core is not running.

Parameters:
- ADDR_W, 8, data-memory address width
- DATA_W, 8, data-memory word width
- CNT_W, 16, cycle-counter width
- TIMEOUT, 16'hFFF0, maximum RUN cycles before abort (must be < 2^CNT_W)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 WRITE, 01 READ, 10 RUN, 11 reserved
- cmd_addr  in  ADDR_W  memory address (WRITE/READ)
- cmd_wdata  in  DATA_W  write data (WRITE)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  DATA_W  read data / cycle count low byte / 0
- rsp_status  out  2  00 OK, 01 TIMEOUT, 10 BAD_OP
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_wen  out  1  data-memory write enable
- mem_rdata  in  DATA_W  data-memory read data
- cpu_start  out  1  one-cycle run-start pulse to core
- cpu_done  in  1  core done flag (registered inside core)
- cycle_count  out  CNT_W  cycles spent in the last RUN
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - state IDLE.
  - cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_status=00.
  - mem_addr=0; mem_wdata=0; mem_wen=0.
  - cpu_start=0; cycle_count=0; busy=0.
- Reset mid-operation aborts immediately: no partial write, no response, cpu_start deasserts.
- Command accepted on the cycle where cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Command fields are captured into registers on acceptance.
- States: IDLE, WRITE, READ_ADDR, READ_CAP, START, RUN, RESP.
- IDLE: on accept, go to WRITE/READ_ADDR/START per cmd_op. op 11 goes to RESP with status BAD_OP, data 0.
- WRITE: one cycle with mem_wen=1, mem_addr/mem_wdata from captured fields -> RESP (OK, data 0).
- READ_ADDR: drive mem_addr -> READ_CAP. READ_CAP: keep mem_addr, sample mem_rdata into rsp_data -> RESP (OK). This tolerates both combinational and 1-cycle registered memory reads.
- START: cpu_start=1 for exactly this cycle; cycle_count cleared to 0 -> RUN.
- RUN:
  - mem_wen=0; the core owns memory.
  - cycle_count increments every cycle.
  - cpu_done is ignored on the first RUN cycle (stale done from a previous run).
  - From the second RUN cycle, cpu_done=1 -> RESP (OK, rsp_data=cycle_count[DATA_W-1:0]).
- Timeout: if cycle_count reaches TIMEOUT before done -> RESP (TIMEOUT, rsp_data=8'hFF). cycle_count holds at TIMEOUT.
- Simultaneous done and timeout in the same cycle: done wins, status OK.
- RESP: rsp_valid=1, rsp_data/rsp_status stable until rsp_ready. Handshake cycle returns to IDLE; no new command is accepted in that same cycle.
- cycle_count holds its value in every state except START and RUN.
- mem_wen is never high outside WRITE.

Decomposition:
- Package cpu_ctl_pkg:
  - enum ctl_state_t for the states.
  - enum cmd_op_t: OP_WRITE=2'b00, OP_READ=2'b01, OP_RUN=2'b10.
  - enum rsp_status_t: ST_OK, ST_TIMEOUT, ST_BAD_OP.
- Single module; the cycle counter is inline (no sub-module warranted).

Test Plan:
- WRITE addr 8'h10, data 8'hA5, then READ 8'h10 -> two OK responses, second with rsp_data=8'hA5; mem_wen high exactly 1 cycle.
- RUN with a core model asserting cpu_done 37 cycles after cpu_start -> single cpu_start pulse, response OK, rsp_data=8'd37 (or per-cycle definition, checked against cycle_count), busy high throughout.
- RUN with cpu_done stuck low, TIMEOUT=16'd20 -> response TIMEOUT, rsp_data=8'hFF, cycle_count=20.
- cpu_done already high when START issues -> not accepted in first RUN cycle; response OK with rsp_data=8'd2 (done seen at second RUN cycle).
- cmd_op=11 -> BAD_OP, no mem_wen, no cpu_start; hold rsp_ready low 5 cycles -> rsp_valid/data/status stable, cmd_ready=0 until handshake.
- Assert reset during RUN at cycle 10 -> all outputs return to reset values next edge; following WRITE/READ works normally.
